// File: rtl/ofs_pkg.sv
// Shared definitions for the output set/preset register bank.
//   OFS_MAX_STAGES : deepest pipeline supported
//   ofs_cnt_w()    : width of the fill counter for a given depth
//   ofs_ctl_t      : per-stage control bits riding alongside the data
// Optional feature macro: OFS_PIPE_TRI_EN adds a tristate-request bit (ts)
// to every stage record.
package ofs_pkg;

  localparam int OFS_MAX_STAGES = 8;
  localparam int OFS_MAX_WIDTH  = 64;

  // Counter must hold the value STAGES itself, hence +1.
  function automatic int ofs_cnt_w(input int stages);
    int w;
    w = $clog2(stages + 1);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic valid;
`ifdef OFS_PIPE_TRI_EN
    logic ts;
`endif
  } ofs_ctl_t;

endpackage

// File: rtl/ofs_stage.sv
// One register stage of the output bank.
//   clk   : clock
//   rst   : synchronous active-high reset, loads INIT and clears valid
//   en    : clock enable; 0 holds the stage
//   d     : WIDTH-bit data in
//   ctl_d : control bits in (valid, optional ts)
//   q     : registered data
//   ctl_q : registered control bits
// With OFS_PIPE_TRI_EN the ts bit resets to 1 so the pad floats in reset.
module ofs_stage
  import ofs_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  ofs_ctl_t         ctl_d,
  output logic [WIDTH-1:0] q,
  output ofs_ctl_t         ctl_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= INIT;
      ctl_q.valid <= 1'b0;
`ifdef OFS_PIPE_TRI_EN
      ctl_q.ts    <= 1'b1;
`endif
    end else if (en) begin
      q     <= d;
      ctl_q <= ctl_d;
    end
  end

endmodule

// File: rtl/ofs_pipe_bank.sv
// WIDTH-bit output register bank, STAGES deep, between core logic and pads.
// Every bit resets to its INIT value (1 = set, 0 = clear); SP freezes the
// whole pipeline and the fill counter without losing data.
// Ports:
//   SCLK   : clock
//   LSR    : synchronous active-high reset (wins over SP)
//   SP     : clock enable
//   D, DV  : data and its valid qualifier from the core
//   Q      : data to pad (last stage)
//   QV     : valid of Q, gated by pipeline-filled
//   FILLED : STAGES enabled edges seen since reset
//   TS, TQ : tristate request in / aligned out (only with OFS_PIPE_TRI_EN)
// Optional feature macro: OFS_PIPE_TRI_EN.
module ofs_pipe_bank
  import ofs_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               STAGES = 2,
  parameter logic [WIDTH-1:0] INIT   = WIDTH'('hFF)
) (
  input  logic             SCLK,
  input  logic             LSR,
  input  logic             SP,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
`ifdef OFS_PIPE_TRI_EN
  input  logic             TS,
  output logic             TQ,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             FILLED
);

  generate
    if (STAGES < 1 || STAGES > OFS_MAX_STAGES || WIDTH < 1 || WIDTH > OFS_MAX_WIDTH) begin : g_bad_param
      $error("ofs_pipe_bank: illegal parameters WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end
  endgenerate

  localparam int CW = ofs_cnt_w(STAGES);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    ofs_ctl_t         ctl;
  } ofs_rec_t;

  ofs_rec_t [STAGES-1:0] rec_in;
  ofs_rec_t [STAGES-1:0] rec_q;
  ofs_ctl_t              ctl_src;

  always_comb begin
    ctl_src       = '0;
    ctl_src.valid = DV;
`ifdef OFS_PIPE_TRI_EN
    ctl_src.ts    = TS;
`endif
  end

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign rec_in[i] = '{data: D, ctl: ctl_src};
      end else begin : g_link
        assign rec_in[i] = rec_q[i-1];
      end

      ofs_stage #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
      ) u_stage (
        .clk   (SCLK),
        .rst   (LSR),
        .en    (SP),
        .d     (rec_in[i].data),
        .ctl_d (rec_in[i].ctl),
        .q     (rec_q[i].data),
        .ctl_q (rec_q[i].ctl)
      );
    end
  endgenerate

  // Fill tracking. FILLED and QV are registered from their next-state
  // values so both leave the block straight from a flop.
  logic [CW-1:0] fill_cnt;
  logic          filled_r;
  logic          qv_r;
  logic          filled_nxt;

  assign filled_nxt = filled_r | (fill_cnt == CW'(STAGES - 1));

  always_ff @(posedge SCLK) begin
    if (LSR) begin
      fill_cnt <= '0;
      filled_r <= 1'b0;
      qv_r     <= 1'b0;
    end else if (SP) begin
      if (fill_cnt != CW'(STAGES)) fill_cnt <= fill_cnt + 1'b1;
      filled_r <= filled_nxt;
      // Redundant with the pipelined valid by construction; kept as a guard.
      qv_r     <= rec_in[STAGES-1].ctl.valid & filled_nxt;
    end
  end

  assign Q      = rec_q[STAGES-1].data;
  assign QV     = qv_r;
  assign FILLED = filled_r;
`ifdef OFS_PIPE_TRI_EN
  assign TQ     = rec_q[STAGES-1].ctl.ts;
`endif

endmodule

// File: tb/tb_ofs_pipe_bank.sv
module tb_ofs_pipe_bank;

  localparam int         W    = 8;
  localparam int         S    = 3;
  localparam logic [7:0] INIT = 8'hA5;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       lsr, sp, dv, ts;
  logic [7:0] d;
  logic [7:0] q;
  logic       qv, filled;
`ifdef OFS_PIPE_TRI_EN
  logic       tq;
`endif

  ofs_pipe_bank #(.WIDTH(W), .STAGES(S), .INIT(INIT)) dut (
    .SCLK   (clk),
    .LSR    (lsr),
    .SP     (sp),
    .D      (d),
    .DV     (dv),
`ifdef OFS_PIPE_TRI_EN
    .TS     (ts),
    .TQ     (tq),
`endif
    .Q      (q),
    .QV     (qv),
    .FILLED (filled)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: queue front is the word currently expected on Q.
  logic [7:0] md[$];
  logic       mv[$];
  logic       mt[$];
  int         mfill = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (lsr) begin
      md.delete(); mv.delete(); mt.delete();
      for (int k = 0; k < S; k++) begin
        md.push_back(INIT); mv.push_back(1'b0); mt.push_back(1'b1);
      end
      mfill = 0;
    end else if (sp) begin
      void'(md.pop_front()); void'(mv.pop_front()); void'(mt.pop_front());
      md.push_back(d); mv.push_back(dv); mt.push_back(ts);
      if (mfill < S) mfill++;
    end
  endtask

  task automatic cyc(input logic l, input logic s, input logic [7:0] dd,
                     input logic v, input logic t, input bit use_model);
    @(negedge clk);
    lsr = l; sp = s; d = dd; dv = v; ts = t;
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) begin
      chk("q", q, md[0]);
      chk("qv", {7'd0, qv}, {7'd0, mv[0] && (mfill == S)});
      chk("filled", {7'd0, filled}, {7'd0, mfill == S});
`ifdef OFS_PIPE_TRI_EN
      chk("tq", {7'd0, tq}, {7'd0, mt[0]});
`endif
    end
  endtask

  typedef struct {
    logic       lsr, sp;
    logic [7:0] d;
    logic       dv, ts;
    logic [7:0] eq;
    logic       eqv, ef, etq;
  } vec_t;

  vec_t vec[9];

  initial begin
    lsr = 1'b1; sp = 1'b0; d = '0; dv = 1'b0; ts = 1'b1;

    // Reset held two edges with D toggling, then latency with D=1..4.
    vec[0] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    vec[1] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    vec[2] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
    vec[3] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
    vec[4] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
    vec[5] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0};
    vec[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0};
    vec[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 1'b1, 1'b0};
    vec[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      cyc(vec[i].lsr, vec[i].sp, vec[i].d, vec[i].dv, vec[i].ts, 1'b0);
      chk($sformatf("vec%0d_q", i), q, vec[i].eq);
      chk($sformatf("vec%0d_qv", i), {7'd0, qv}, {7'd0, vec[i].eqv});
      chk($sformatf("vec%0d_filled", i), {7'd0, filled}, {7'd0, vec[i].ef});
`ifdef OFS_PIPE_TRI_EN
      chk($sformatf("vec%0d_tq", i), {7'd0, tq}, {7'd0, vec[i].etq});
`endif
    end

    // Stall: 7 enters, five frozen edges, then two more enabled edges.
    cyc(1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b1);
    chk("stall_q", q, 8'h07);

    // Fill counts enabled edges only, not clocks.
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, (i % 2 == 0), 8'(i + 8'h40), 1'b1, 1'b0, 1'b1);
      if (i == 3) chk("fill_4th_clk", {7'd0, filled}, 8'd0);
      if (i == 4) chk("fill_3rd_en",  {7'd0, filled}, 8'd1);
    end

    // Mid-operation reset with SP=1 discards the pipeline.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    chk("full_q", q, 8'h3C);
    cyc(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    chk("midrst_q", q, INIT);
    chk("midrst_qv", {7'd0, qv}, 8'd0);
    for (int i = 0; i < S; i++) cyc(1'b0, 1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b1);
    chk("refill_q", q, 8'h50);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 80; i++)
      cyc(($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
